// File: rtl/pwm_seq_ctrl.sv
// pwm_seq_ctrl: plays a programmable table of duty values into the PWM core.
// Each entry is held for (rep+1) PWM periods. Playback is either one-shot or looping.
// The table is read combinationally in the LOAD cycle, so a write that lands
// in the LOAD cycle itself does not reach the core. A write that lands earlier does.
module pwm_seq_ctrl #(
  parameter int DW    = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          start,
  input  logic          stop,
  input  logic          loop_mode,
  input  logic [7:0]    rep_cnt,
  input  logic [AW:0]   seq_len,
  input  logic          period_end,
  output logic          pwm_en,
  output logic [DW-1:0] duty,
  output logic          duty_load,
  output logic [AW-1:0] idx,
  output logic          busy,
  output logic          done
);

  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LEN_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] IDX_ONE = AW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN
  } state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] table_q [DEPTH];
  logic [DW-1:0] rd_data;
  logic [DW-1:0] duty_q;
  logic [AW:0]   len_q;
  logic [7:0]    rep_q;
  logic [7:0]    rem_q;
  logic          start_acc;
  logic          advance;
  logic          wrap;
  logic          finish;
  logic          rem_dec;

  // Duty table storage. It is never reset and it accepts writes in every state.
  always_ff @(posedge HCLK) begin
    if (wr_en) begin
      table_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = table_q[idx];

  // FSM state register
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and one-cycle action strobes. stop has the highest priority.
  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    advance   = 1'b0;
    wrap      = 1'b0;
    finish    = 1'b0;
    rem_dec   = 1'b0;
    if (stop) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && (seq_len != '0)) begin
            start_acc = 1'b1;
            state_nxt = S_LOAD;
          end
        end
        S_LOAD: begin
          state_nxt = S_RUN;
        end
        S_RUN: begin
          if (period_end) begin
            if (rem_q != '0) begin
              rem_dec = 1'b1;
            end else if ({1'b0, idx} != (len_q - LEN_ONE)) begin
              advance   = 1'b1;
              state_nxt = S_LOAD;
            end else if (loop_mode) begin
              wrap      = 1'b1;
              state_nxt = S_LOAD;
            end else begin
              finish    = 1'b1;
              state_nxt = S_IDLE;
            end
          end
        end
        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Sequencer registers: captured run parameters, entry index, repeat count,
  // the held duty value, and the done pulse.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      idx    <= '0;
      rem_q  <= '0;
      rep_q  <= '0;
      len_q  <= '0;
      duty_q <= '0;
      done   <= 1'b0;
    end else begin
      done <= finish;
      if (start_acc) begin
        idx   <= '0;
        len_q <= (seq_len > DEPTH_L) ? DEPTH_L : seq_len;
        rep_q <= rep_cnt;
      end
      if (advance) begin
        idx <= idx + IDX_ONE;
      end
      if (wrap) begin
        idx <= '0;
      end
      if (state == S_LOAD) begin
        duty_q <= rd_data;
        rem_q  <= rep_q;
      end
      if (rem_dec) begin
        rem_q <= rem_q - 8'd1;
      end
    end
  end

  // In the LOAD cycle, the fresh table value is already on duty alongside the strobe.
  assign busy      = (state != S_IDLE);
  assign pwm_en    = busy;
  assign duty_load = (state == S_LOAD);
  assign duty      = duty_load ? rd_data : duty_q;

endmodule
